// File: rtl/mux_logic_unit.sv
// Two-stage valid/ready pipeline: each result bit is a 2:1 mux selected by a[i] with op-dependent data from b[i].
// Optional statistics (op_count port and saturating counter) enabled by defining MLU_STATS_EN.
module mux_logic_unit #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
`ifdef MLU_STATS_EN
   output logic [15:0]      op_count,
`endif
   output logic [WIDTH-1:0] y,
   output logic [2:0]       out_op
);

   // Handshake: a transfer happens on any cycle where valid && ready; a producer holds its data
   // stable while valid is high and ready is low, and ready never waits on valid.
   logic             s1_valid_q, s1_valid_d;
   logic [WIDTH-1:0] s1_a_q, s1_a_d;
   logic [WIDTH-1:0] s1_b_q, s1_b_d;
   logic [2:0]       s1_op_q, s1_op_d;
   logic             s2_valid_q, s2_valid_d;
   logic [WIDTH-1:0] y_q, y_d;
   logic [2:0]       out_op_q, out_op_d;

   logic             in_fire;
   logic             out_fire;
   logic             s2_load;
   logic [WIDTH-1:0] d0;
   logic [WIDTH-1:0] d1;
   logic [WIDTH-1:0] mux_y;

   assign in_ready = !s1_valid_q || !s2_valid_q || out_ready;
   assign in_fire  = in_valid && in_ready;
   assign out_fire = s2_valid_q && out_ready;
   assign s2_load  = s1_valid_q && (!s2_valid_q || out_ready);

   // d0 feeds the mux input chosen when a[i]=0, d1 the one chosen when a[i]=1.
   always_comb begin
      d0 = '0;
      d1 = '0;
      case (s1_op_q)
         3'b000:  begin d0 = '0;       d1 = s1_b_q;  end
         3'b001:  begin d0 = s1_b_q;   d1 = '1;      end
         3'b010:  begin d0 = '1;       d1 = ~s1_b_q; end
         3'b011:  begin d0 = ~s1_b_q;  d1 = '0;      end
         3'b100:  begin d0 = s1_b_q;   d1 = ~s1_b_q; end
         3'b101:  begin d0 = ~s1_b_q;  d1 = s1_b_q;  end
         3'b110:  begin d0 = '1;       d1 = '0;      end
         default: begin d0 = s1_b_q;   d1 = s1_b_q;  end
      endcase
   end

   assign mux_y = (s1_a_q & d1) | (~s1_a_q & d0);

   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_a_d     = s1_a_q;
      s1_b_d     = s1_b_q;
      s1_op_d    = s1_op_q;
      s2_valid_d = s2_valid_q;
      y_d        = y_q;
      out_op_d   = out_op_q;

      if (in_fire) begin
         s1_valid_d = 1'b1;
         s1_a_d     = a;
         s1_b_d     = b;
         s1_op_d    = op;
      end else if (s2_load) begin
         s1_valid_d = 1'b0;
      end

      // y keeps its last value when the stage drains, only the valid flag drops.
      if (s2_load) begin
         s2_valid_d = 1'b1;
         y_d        = mux_y;
         out_op_d   = s1_op_q;
      end else if (out_fire) begin
         s2_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_a_q     <= '0;
         s1_b_q     <= '0;
         s1_op_q    <= 3'b000;
         s2_valid_q <= 1'b0;
         y_q        <= '0;
         out_op_q   <= 3'b000;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_a_q     <= s1_a_d;
         s1_b_q     <= s1_b_d;
         s1_op_q    <= s1_op_d;
         s2_valid_q <= s2_valid_d;
         y_q        <= y_d;
         out_op_q   <= out_op_d;
      end
   end

   assign out_valid = s2_valid_q;
   assign y         = y_q;
   assign out_op    = out_op_q;

`ifdef MLU_STATS_EN
   logic [15:0] op_count_q, op_count_d;

   always_comb begin
      op_count_d = op_count_q;
      if (out_fire && (op_count_q != 16'hFFFF)) begin
         op_count_d = op_count_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         op_count_q <= 16'd0;
      end else begin
         op_count_q <= op_count_d;
      end
   end

   assign op_count = op_count_q;
`endif

endmodule

// File: tb/tb_mux_logic_unit.sv
// Bench for mux_logic_unit: WIDTH=8 instance for streaming, stall and reset behaviour,
// plus a WIDTH=1 instance swept over all 32 a/b/op combinations.
module tb_mux_logic_unit;

   localparam int W = 8;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [2:0]   op;
      logic [W-1:0] exp_y;
   } vec_t;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic [2:0]   op = 3'b000;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] y;
   logic [2:0]   out_op;

   logic         w1_in_valid = 1'b0;
   logic         w1_in_ready;
   logic         w1_a = 1'b0;
   logic         w1_b = 1'b0;
   logic [2:0]   w1_op = 3'b000;
   logic         w1_out_valid;
   logic         w1_out_ready = 1'b1;
   logic         w1_y;
   logic [2:0]   w1_out_op;
`ifdef MLU_STATS_EN
   logic [15:0]  op_count;
   logic [15:0]  w1_op_count;
`endif

   mux_logic_unit #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .op        (op),
      .out_valid (out_valid),
      .out_ready (out_ready),
`ifdef MLU_STATS_EN
      .op_count  (op_count),
`endif
      .y         (y),
      .out_op    (out_op)
   );

   mux_logic_unit #(.WIDTH(1)) dut_w1 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (w1_in_valid),
      .in_ready  (w1_in_ready),
      .a         (w1_a),
      .b         (w1_b),
      .op        (w1_op),
      .out_valid (w1_out_valid),
      .out_ready (w1_out_ready),
`ifdef MLU_STATS_EN
      .op_count  (w1_op_count),
`endif
      .y         (w1_y),
      .out_op    (w1_out_op)
   );

   always #5 clk = ~clk;

   logic [W+2:0] exp_q[$];
   int           checks = 0;
   int           fails = 0;
   logic         last_acc = 1'b0;
   int           rx_since_rst = 0;
   logic         rand_bp = 1'b0;
   vec_t         vecs[16];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Independent bit-level reference built from the (i0, i1) operation table.
   function automatic logic [W-1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                          input logic [2:0] mop);
      logic [W-1:0] r;
      logic         i0;
      logic         i1;
      r = '0;
      for (int i = 0; i < W; i++) begin
         case (mop)
            3'd0:    begin i0 = 1'b0;    i1 = mb[i];  end
            3'd1:    begin i0 = mb[i];   i1 = 1'b1;   end
            3'd2:    begin i0 = 1'b1;    i1 = ~mb[i]; end
            3'd3:    begin i0 = ~mb[i];  i1 = 1'b0;   end
            3'd4:    begin i0 = mb[i];   i1 = ~mb[i]; end
            3'd5:    begin i0 = ~mb[i];  i1 = mb[i];  end
            3'd6:    begin i0 = 1'b1;    i1 = 1'b0;   end
            default: begin i0 = mb[i];   i1 = mb[i];  end
         endcase
         r[i] = ma[i] ? i1 : i0;
      end
      return r;
   endfunction

   // Scoreboard: pops and compares every output transfer, records input acceptance.
   always @(negedge clk) begin
      logic [W+2:0] e;
      last_acc = in_valid && in_ready && !rst;
      if (rst) begin
         exp_q.delete();
         rx_since_rst = 0;
      end else if (out_valid && out_ready) begin
         rx_since_rst++;
         if (exp_q.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL unexpected_out: got y=%0h op=%0d, expected no result", y, out_op);
         end else begin
            e = exp_q.pop_front();
            check("sb_y", y, e[W-1:0]);
            check("sb_out_op", out_op, e[W+2:W]);
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
      end
   end

   // Presents one item and holds it until accepted; called at posedge+1.
   task automatic push_item(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                            input logic [2:0] top, input logic [W-1:0] ty);
      int guard;
      in_valid = 1'b1;
      a        = ta;
      b        = tb_v;
      op       = top;
      guard    = 0;
      do begin
         @(posedge clk);
         #1;
         guard++;
      end while (!last_acc && guard < 200);
      if (!last_acc) begin
         checks++;
         fails++;
         $display("FAIL push_timeout: op=%0d not accepted in 200 cycles, expected acceptance", top);
      end else begin
         exp_q.push_back({top, ty});
      end
   endtask

   task automatic drain();
      int g;
      g = 0;
      while (exp_q.size() != 0 && g < 300) begin
         @(negedge clk);
         g++;
      end
      if (exp_q.size() != 0) begin
         checks++;
         fails++;
         $display("FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [W-1:0] y_hold;
      logic [W-1:0] ra, rb, wm;
      logic [2:0]   rop;
      logic [4:0]   c;

      vecs[0]  = '{8'hF0, 8'hCC, 3'd0, 8'hC0};
      vecs[1]  = '{8'hF0, 8'hCC, 3'd1, 8'hFC};
      vecs[2]  = '{8'hF0, 8'hCC, 3'd2, 8'h3F};
      vecs[3]  = '{8'hF0, 8'hCC, 3'd3, 8'h03};
      vecs[4]  = '{8'hF0, 8'hCC, 3'd4, 8'h3C};
      vecs[5]  = '{8'hF0, 8'hCC, 3'd5, 8'hC3};
      vecs[6]  = '{8'hF0, 8'hCC, 3'd6, 8'h0F};
      vecs[7]  = '{8'hF0, 8'hCC, 3'd7, 8'hCC};
      vecs[8]  = '{8'h00, 8'h5A, 3'd0, 8'h00};
      vecs[9]  = '{8'h00, 8'h5A, 3'd1, 8'h5A};
      vecs[10] = '{8'h00, 8'h5A, 3'd6, 8'hFF};
      vecs[11] = '{8'h00, 8'h5A, 3'd3, 8'hA5};
      vecs[12] = '{8'hFF, 8'h5A, 3'd2, 8'hA5};
      vecs[13] = '{8'hFF, 8'h5A, 3'd5, 8'h5A};
      vecs[14] = '{8'hFF, 8'h5A, 3'd4, 8'hA5};
      vecs[15] = '{8'hFF, 8'h5A, 3'd6, 8'h00};

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("rst_in_ready", in_ready, 1'b1);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_y", y, 8'h00);
      check("rst_out_op", out_op, 3'b000);
`ifdef MLU_STATS_EN
      check("rst_op_count", op_count, 16'd0);
`endif
      @(posedge clk);
      #1;

      // Full op table back-to-back with a latency check on the first item
      out_ready = 1'b1;
      fork
         begin
            for (int i = 0; i < 8; i++) push_item(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].exp_y);
            in_valid = 1'b0;
         end
         begin
            @(negedge clk);
            @(negedge clk);
            check("lat_cycle1_valid", out_valid, 1'b0);
            @(negedge clk);
            check("lat_cycle2_valid", out_valid, 1'b1);
            check("lat_cycle2_y", y, 8'hC0);
         end
      join
      drain();
      repeat (3) @(negedge clk);
      check("idle_out_valid", out_valid, 1'b0);
      check("idle_y_hold", y, 8'hCC);
      check("idle_out_op_hold", out_op, 3'd7);
      @(posedge clk);
      #1;

      for (int i = 8; i < 16; i++) push_item(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].exp_y);
      in_valid = 1'b0;
      drain();

      // Backpressure: out_ready low for 5 cycles with 4 inputs offered
      out_ready = 1'b0;
      fork
         begin
            push_item(8'h0F, 8'h33, 3'd0, 8'h03);
            push_item(8'h0F, 8'h33, 3'd1, 8'h3F);
            push_item(8'h0F, 8'h33, 3'd4, 8'h3C);
            push_item(8'h0F, 8'h33, 3'd7, 8'h33);
            in_valid = 1'b0;
         end
         begin
            @(negedge clk);
            @(negedge clk);
            @(negedge clk);
            check("bp_full_in_ready", in_ready, 1'b0);
            check("bp_full_out_valid", out_valid, 1'b1);
            check("bp_full_y", y, 8'h03);
            y_hold = y;
            repeat (2) begin
               @(negedge clk);
               check("bp_stall_y", y, y_hold);
               check("bp_stall_out_op", out_op, 3'd0);
               check("bp_stall_in_ready", in_ready, 1'b0);
            end
            @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      drain();

      // Reset with both stages full discards everything in flight
      out_ready = 1'b0;
      push_item(8'hFF, 8'h00, 3'd6, 8'h00);
      push_item(8'h00, 8'h00, 3'd6, 8'hFF);
      in_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("mid_rst_out_valid", out_valid, 1'b0);
      check("mid_rst_y", y, 8'h00);
      check("mid_rst_out_op", out_op, 3'b000);
      check("mid_rst_in_ready", in_ready, 1'b1);
      out_ready = 1'b1;
      repeat (10) @(negedge clk);
      check("mid_rst_no_stale", out_valid, 1'b0);
      @(posedge clk);
      #1;

      // Ten transfers after reset for the statistics counter
      for (int i = 0; i < 10; i++) push_item(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].exp_y);
      in_valid = 1'b0;
      drain();
`ifdef MLU_STATS_EN
      check("op_count_10", op_count, 16'd10);
`endif

      // Random in_valid/out_ready over 1000 transfers
      rand_bp = 1'b1;
      for (int n = 0; n < 1000; n++) begin
         if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            @(posedge clk);
            #1;
         end
         ra  = W'($urandom_range(0, 255));
         rb  = W'($urandom_range(0, 255));
         rop = 3'($urandom_range(0, 7));
         push_item(ra, rb, rop, model(ra, rb, rop));
      end
      in_valid = 1'b0;
      rand_bp  = 1'b0;
      @(posedge clk);
      #2;
      out_ready = 1'b1;
      drain();
      check("rand_rx_count", rx_since_rst, 1010);
`ifdef MLU_STATS_EN
      check("op_count_total", op_count, 16'd1010);
`endif

      // WIDTH=1: every a, b, op combination
      for (int k = 0; k < 32; k++) begin
         c           = 5'(k);
         w1_a        = c[4];
         w1_b        = c[3];
         w1_op       = c[2:0];
         w1_in_valid = 1'b1;
         @(posedge clk);
         #1;
         w1_in_valid = 1'b0;
         @(negedge clk);
         @(negedge clk);
         wm = model({7'b0, c[4]}, {7'b0, c[3]}, c[2:0]);
         check("w1_out_valid", w1_out_valid, 1'b1);
         check("w1_y", w1_y, wm[0]);
         check("w1_out_op", w1_out_op, c[2:0]);
         @(posedge clk);
         #1;
      end

      $display("[TB] %0d tests run, %0d failed", checks, fails);
      $finish;
   end

   initial begin
      #600000;
      checks++;
      fails++;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $display("[TB] %0d tests run, %0d failed", checks, fails);
      $finish;
   end

endmodule
